// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one combinational adder between several clients.
// The winning client's operands pass through the single Adder instance. The
// result is captured in an output register and held under valid/ready.

// Plain unsigned adder; carry-out is the (BITS+1)th bit of the exact sum.
module Adder #(
    parameter int BITS = 8
) (
    input  logic [BITS-1:0] i_augend,
    input  logic [BITS-1:0] i_addend,
    output logic [BITS-1:0] o_sum,
    output logic            o_carry
);
    // Exact sum over BITS+1 bits.
    assign {o_carry, o_sum} = {1'b0, i_augend} + {1'b0, i_addend};
endmodule

// State table
//   state   | meaning
//   S_EMPTY | output register holds no unconsumed result (o_valid = 0)
//   S_FULL  | output register holds a result awaiting i_ready (o_valid = 1)
module adder_arbiter #(
    parameter int BITS       = 8,
    parameter int REQUESTERS = 4,
    parameter int INDEX_BITS = $clog2(REQUESTERS)
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [REQUESTERS-1:0]      i_request,
    input  logic [REQUESTERS*BITS-1:0] i_augend,
    input  logic [REQUESTERS*BITS-1:0] i_addend,
    output logic [REQUESTERS-1:0]      o_grant,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [BITS-1:0]            o_sum,
    output logic                       o_carry,
    output logic [INDEX_BITS-1:0]      o_requester
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [INDEX_BITS-1:0] r_pointer;
    logic [BITS-1:0]       r_sum;
    logic                  r_carry;
    logic [INDEX_BITS-1:0] r_requester;

    logic                  w_accept;
    logic                  w_found;
    logic                  w_grant_any;
    logic [INDEX_BITS-1:0] w_winner;
    logic [INDEX_BITS:0]   w_scan;
    logic [INDEX_BITS-1:0] w_pointer_next;
    logic [BITS-1:0]       w_augend;
    logic [BITS-1:0]       w_addend;
    logic [BITS-1:0]       w_sum;
    logic                  w_carry;

    // The register can take a new result when empty or being drained this cycle.
    assign w_accept = !i_reset && (!o_valid || i_ready);

    // Scan requests starting at the pointer, wrapping at REQUESTERS-1; the
    // scan index is kept one bit wider so non-power-of-two counts wrap cleanly.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_scan   = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            w_scan = {1'b0, r_pointer} + (INDEX_BITS+1)'(i);
            if (w_scan >= (INDEX_BITS+1)'(REQUESTERS)) begin
                w_scan = w_scan - (INDEX_BITS+1)'(REQUESTERS);
            end
            if (!w_found && i_request[w_scan[INDEX_BITS-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_scan[INDEX_BITS-1:0];
            end
        end
    end

    assign w_grant_any    = w_accept && w_found;
    assign o_grant        = w_grant_any ? (REQUESTERS'(1) << w_winner) : '0;
    assign w_pointer_next = (w_winner == INDEX_BITS'(REQUESTERS - 1)) ?
                            '0 : (w_winner + INDEX_BITS'(1));

    assign w_augend = i_augend[int'(w_winner)*BITS +: BITS];
    assign w_addend = i_addend[int'(w_winner)*BITS +: BITS];

    Adder #(
        .BITS(BITS)
    ) u_adder (
        .i_augend(w_augend),
        .i_addend(w_addend),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    // State register; reset discards any held result.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: a grant always fills; draining without a grant empties.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_EMPTY: begin
                if (w_grant_any) begin
                    w_state_next = S_FULL;
                end
            end
            S_FULL: begin
                if (w_grant_any) begin
                    w_state_next = S_FULL;
                end else if (i_ready) begin
                    w_state_next = S_EMPTY;
                end
            end
            default: w_state_next = S_EMPTY;
        endcase
    end

    // Result and pointer load only on a grant; otherwise they hold.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_requester <= '0;
            r_pointer   <= '0;
        end else if (w_grant_any) begin
            r_sum       <= w_sum;
            r_carry     <= w_carry;
            r_requester <= w_winner;
            r_pointer   <= w_pointer_next;
        end
    end

    assign o_valid     = (r_state == S_FULL);
    assign o_sum       = r_sum;
    assign o_carry     = r_carry;
    assign o_requester = r_requester;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: fixed vector table, a REQUESTERS=3
// wrap sequence, randomized traffic against a reference model, and an
// exhaustive 8-bit addition sweep through client 0.
module tb_adder_arbiter;

    localparam int BITS = 8;
    localparam int R    = 4;
    localparam int R3   = 3;

    logic          clk;
    logic          rst;
    logic [R-1:0]  req;
    logic [31:0]   aug;
    logic [31:0]   add;
    logic          rdy;
    logic [R-1:0]  grant;
    logic          valid;
    logic [7:0]    sum;
    logic          carry;
    logic [1:0]    requester;

    logic          rst3;
    logic [R3-1:0] req3;
    logic [23:0]   aug3;
    logic [23:0]   add3;
    logic          rdy3;
    logic [R3-1:0] grant3;
    logic          valid3;
    logic [7:0]    sum3;
    logic          carry3;
    logic [1:0]    requester3;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_ptr, m_valid, m_sum, m_carry, m_req;

    adder_arbiter #(.BITS(BITS), .REQUESTERS(R)) dut (
        .i_clock(clk), .i_reset(rst), .i_request(req),
        .i_augend(aug), .i_addend(add), .o_grant(grant),
        .o_valid(valid), .i_ready(rdy), .o_sum(sum),
        .o_carry(carry), .o_requester(requester)
    );

    adder_arbiter #(.BITS(BITS), .REQUESTERS(R3)) dut3 (
        .i_clock(clk), .i_reset(rst3), .i_request(req3),
        .i_augend(aug3), .i_addend(add3), .o_grant(grant3),
        .o_valid(valid3), .i_ready(rdy3), .o_sum(sum3),
        .o_carry(carry3), .o_requester(requester3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic         rst;
        logic [3:0]   req;
        logic [31:0]  aug;
        logic [31:0]  add;
        logic         rdy;
        logic [3:0]   e_grant;
        logic         e_valid;
        logic [7:0]   e_sum;
        logic         e_carry;
        logic [1:0]   e_req;
    } vec_t;

    vec_t vt[24];

    // One cycle against the reference model: inputs are already applied.
    task automatic model_step();
        int accept, win, k, s, a, b, exp_grant;
        #1;
        accept = (!rst && (!m_valid || rdy)) ? 1 : 0;
        win = -1;
        for (int i = 0; i < R; i++) begin
            k = (m_ptr + i) % R;
            if (win < 0 && req[k]) win = k;
        end
        exp_grant = (accept != 0 && win >= 0) ? (1 << win) : 0;
        chk("grant", int'(grant), exp_grant);
        if (rst) begin
            m_ptr = 0; m_valid = 0; m_sum = 0; m_carry = 0; m_req = 0;
        end else if (exp_grant != 0) begin
            a = int'(aug[win*8 +: 8]);
            b = int'(add[win*8 +: 8]);
            s = a + b;
            m_sum = s % 256;
            m_carry = s / 256;
            m_req = win;
            m_valid = 1;
            m_ptr = (win + 1) % R;
        end else if (m_valid != 0 && rdy) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        chk("valid", int'(valid), m_valid);
        chk("sum", int'(sum), m_sum);
        chk("carry", int'(carry), m_carry);
        chk("requester", int'(requester), m_req);
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [31:0] au,
                                input logic [31:0] ad, input logic y, input logic [3:0] g,
                                input logic v, input logic [7:0] s, input logic c,
                                input logic [1:0] w);
        vec_t t;
        t.rst = r; t.req = q; t.aug = au; t.add = ad; t.rdy = y;
        t.e_grant = g; t.e_valid = v; t.e_sum = s; t.e_carry = c; t.e_req = w;
        return t;
    endfunction

    initial begin
        logic [31:0] op_a, op_b, op_single;
        int g3_exp[4];
        int r3_exp[4];

        // client k augend 16*(k+1), addend 250: sums 10,26,42,58 with carry
        op_a = 32'h40_30_20_10;
        op_b = 32'hFA_FA_FA_FA;
        op_single = 32'h00_C8_00_00;           // client 2 augend 200
        vt[0]  = mk(1, 4'b0000, op_a, op_b, 1, 4'b0000, 0, 0, 0, 0);
        vt[1]  = mk(0, 4'b0100, op_single, 32'h00_64_00_00, 1, 4'b0100, 1, 44, 1, 2);
        vt[2]  = mk(0, 4'b0000, op_a, op_b, 1, 4'b0000, 0, 44, 1, 2);
        vt[3]  = mk(1, 4'b1111, op_a, op_b, 1, 4'b0000, 0, 0, 0, 0);
        vt[4]  = mk(0, 4'b1111, op_a, op_b, 1, 4'b0001, 1, 10, 1, 0);
        vt[5]  = mk(0, 4'b1111, op_a, op_b, 1, 4'b0010, 1, 26, 1, 1);
        vt[6]  = mk(0, 4'b1111, op_a, op_b, 1, 4'b0100, 1, 42, 1, 2);
        vt[7]  = mk(0, 4'b1111, op_a, op_b, 1, 4'b1000, 1, 58, 1, 3);
        vt[8]  = mk(0, 4'b1111, op_a, op_b, 1, 4'b0001, 1, 10, 1, 0);
        vt[9]  = mk(0, 4'b1111, op_a, op_b, 1, 4'b0010, 1, 26, 1, 1);
        vt[10] = mk(0, 4'b1111, op_a, op_b, 0, 4'b0000, 1, 26, 1, 1);
        vt[11] = mk(0, 4'b1111, op_a, op_b, 0, 4'b0000, 1, 26, 1, 1);
        vt[12] = mk(0, 4'b1111, op_a, op_b, 0, 4'b0000, 1, 26, 1, 1);
        vt[13] = mk(0, 4'b1111, op_a, op_b, 0, 4'b0000, 1, 26, 1, 1);
        vt[14] = mk(0, 4'b1111, op_a, op_b, 0, 4'b0000, 1, 26, 1, 1);
        vt[15] = mk(0, 4'b1111, op_a, op_b, 1, 4'b0100, 1, 42, 1, 2);
        vt[16] = mk(1, 4'b1111, op_a, op_b, 0, 4'b0000, 0, 0, 0, 0);
        vt[17] = mk(0, 4'b1010, op_a, op_b, 0, 4'b0010, 1, 26, 1, 1);
        vt[18] = mk(1, 4'b0000, op_a, op_b, 1, 4'b0000, 0, 0, 0, 0);
        vt[19] = mk(0, 4'b1001, op_a, op_b, 1, 4'b0001, 1, 10, 1, 0);
        vt[20] = mk(0, 4'b1001, op_a, op_b, 1, 4'b1000, 1, 58, 1, 3);
        vt[21] = mk(0, 4'b1001, op_a, op_b, 1, 4'b0001, 1, 10, 1, 0);
        vt[22] = mk(0, 4'b1001, op_a, op_b, 1, 4'b1000, 1, 58, 1, 3);
        vt[23] = mk(0, 4'b0000, op_a, op_b, 1, 4'b0000, 0, 58, 1, 3);

        rst3 = 1'b1; req3 = '0; aug3 = '0; add3 = '0; rdy3 = 1'b1;

        for (int i = 0; i < 24; i++) begin
            rst = vt[i].rst; req = vt[i].req; aug = vt[i].aug;
            add = vt[i].add; rdy = vt[i].rdy;
            #1;
            chk($sformatf("vec%0d_grant", i), int'(grant), int'(vt[i].e_grant));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), int'(valid), int'(vt[i].e_valid));
            chk($sformatf("vec%0d_sum", i), int'(sum), int'(vt[i].e_sum));
            chk($sformatf("vec%0d_carry", i), int'(carry), int'(vt[i].e_carry));
            chk($sformatf("vec%0d_req", i), int'(requester), int'(vt[i].e_req));
        end

        // REQUESTERS=3: clients 0 and 2 alternate, pointer wraps 2->0.
        // Client 2 adds 255+1 so its results also show the carry path.
        rst3 = 1'b0; req3 = 3'b101;
        aug3 = 24'hFF_00_07; add3 = 24'h01_00_03;
        g3_exp = '{1, 4, 1, 4};
        r3_exp = '{0, 2, 0, 2};
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("r3_grant%0d", i), int'(grant3), g3_exp[i]);
            @(posedge clk);
            #1;
            chk($sformatf("r3_req%0d", i), int'(requester3), r3_exp[i]);
            chk($sformatf("r3_sum%0d", i), int'({carry3, sum3}), (r3_exp[i] == 0) ? 10 : 256);
        end
        req3 = '0;

        // randomized traffic against the model
        rst = 1'b1; req = '0; rdy = 1'b1;
        m_ptr = 0; m_valid = 0; m_sum = 0; m_carry = 0; m_req = 0;
        model_step();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            req = R'($urandom_range(0, 15));
            aug = $urandom;
            add = $urandom;
            rdy = ($urandom_range(0, 99) < 65);
            model_step();
        end

        // exhaustive arithmetic through client 0
        rst = 1'b1; req = '0; rdy = 1'b1;
        model_step();
        rst = 1'b0;
        req = 4'b0001;
        for (int x = 0; x < 256; x++) begin
            for (int y = 0; y < 256; y++) begin
                aug = {24'h0, 8'(x)};
                add = {24'hFFFFFF, 8'(y)};
                model_step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter that shares one `Adder` instance between `REQUESTERS` independent clients. Each cycle it selects at most one pending request and routes that client's operands through the shared combinational adder. It captures `{carry, sum}` plus the winner's index in an output register, and holds the result under a valid/ready handshake until the consumer accepts it. It sits between the client blocks and the single adder datapath, so clients never drive the adder directly.

## Interface
Parameters:
- `BITS`, 8, operand and sum width; passed unchanged to `Adder`.
- `REQUESTERS`, 4, number of clients; must be ≥ 2; need not be a power of two.
- `INDEX_BITS`, `$clog2(REQUESTERS)`, width of the requester index (derived; do not override).

Ports:
- `i_clock`  in  1  sole clock; all state updates on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_request`  in  REQUESTERS  bit k high = client k has operands pending.
- `i_augend`  in  REQUESTERS*BITS  packed operands; client k occupies bits [k*BITS +: BITS].
- `i_addend`  in  REQUESTERS*BITS  packed operands, same packing as `i_augend`.
- `o_grant`  out  REQUESTERS  one-hot (or zero) acceptance strobe; combinational.
- `o_valid`  out  1  output register holds an unconsumed result.
- `i_ready`  in  1  consumer accepts the result this cycle.
- `o_sum`  out  BITS  registered sum.
- `o_carry`  out  1  registered carry-out.
- `o_requester`  out  INDEX_BITS  index of the client that produced the held result.

## Operation
- Internal state:
  - `pointer`: highest-priority index, range 0..REQUESTERS-1.
  - Output register: `o_valid`, `o_sum`, `o_carry`, `o_requester`.
- Two states, encoded by `o_valid`:
  - EMPTY (`o_valid`=0).
  - FULL (`o_valid`=1).
- The arbiter can accept a request when `accept = !i_reset && (!o_valid || i_ready)`.
- Winner selection: the first k with `i_request[k]`=1, scanning `pointer`, `pointer`+1, …, wrapping at REQUESTERS-1 → 0.
- Grant: `o_grant[k]`=1 only when `accept` is true and k is the winner; otherwise `o_grant` = 0.
- The winner's operands drive the single `Adder` instance. Only one adder exists in this block.
- On a clock edge with a grant:
  - `o_sum`/`o_carry` ← adder outputs.
  - `o_requester` ← k.
  - `o_valid` ← 1.
  - `pointer` ← k+1, or 0 if k = REQUESTERS-1.
- On an edge with `o_valid && i_ready` and no grant: `o_valid` ← 0. Data registers keep their last values.
- FULL with `i_ready`=0:
  - All output registers hold.
  - `o_grant` = 0.
  - `pointer` holds.
- Simultaneous consume and grant (FULL, `i_ready`=1, request pending):
  - New result loads.
  - `o_valid` stays 1.
  - No bubble.
- No requests pending:
  - No grant.
  - `pointer` unchanged.
- Client contract:
  - Hold `i_request[k]` and the operands stable until the cycle in which `o_grant[k]`=1.
  - In the following cycle, either drop the request or present new operands.
- Arithmetic: `{o_carry, o_sum}` = augend + addend, exact over BITS+1 bits. Operands are unsigned.
- Reset (any cycle, including FULL or mid-handshake), all values on the next edge:
  - `o_valid`=0, `o_sum`=0, `o_carry`=0, `o_requester`=0, `pointer`=0.
  - `o_grant`=0 during the reset cycle.
  - A held result is discarded.

## Timing
- Request → grant: 0 cycles. `o_grant` asserts in the same cycle the request is seen, if `accept` is true.
- Grant → result: 1 cycle. `o_valid` and data are visible from the edge that ends the grant cycle.
- Throughput: one result per cycle while `i_ready`=1 and requests are pending.
- No combinational path from `i_request` or operands to `o_sum`, `o_carry`, `o_valid` or `o_requester`. These outputs change only on clock edges.
- `o_grant` depends combinationally on `i_request`, `i_ready`, `i_reset` and registered state.
- Starvation bound: a client holding its request is granted within REQUESTERS accepted transfers.

## Test plan
- **Single request.** Reset, then client 2 requests 200 + 100 with `i_ready`=1.
  - `o_grant`=4'b0100 in cycle 0.
  - Next cycle: `o_valid`=1, `o_sum`=44, `o_carry`=1, `o_requester`=2.
- **Fairness.** All four clients request continuously; `i_ready`=1.
  - Grant order 0,1,2,3,0,1.
  - One result per cycle with matching `o_requester`.
- **Pointer wrap.** Only clients 0 and 3 request.
  - Grants alternate 3,0,3 after the first grant to 0.
  - `pointer` wraps 3→0 correctly; repeat with REQUESTERS=3.
- **Backpressure.** Hold `i_ready`=0 for 5 cycles while FULL.
  - `o_sum`/`o_carry`/`o_requester` stable and `o_grant`=0 throughout.
  - Raising `i_ready` with a request pending gives a grant in that same cycle and no bubble.
- **Reset mid-operation.** Assert `i_reset` while FULL with requests pending.
  - Next edge: all outputs 0 and `o_grant`=0 during reset.
  - First grant after reset goes to the lowest-index requester.
- **Exhaustive arithmetic.** BITS=8, single client, all 65 536 operand pairs.
  - `{o_carry, o_sum}` equals x + y for every pair.
